// File: rtl/qdrc_cal_pkg.sv
// Shared state encoding, status widths and elaboration helpers for the QDR PHY calibration sequencer.
package qdrc_cal_pkg;

   localparam int FAIL_STAGE_W = 3;
   localparam int RETRY_W      = 4;

   localparam logic [1:0] ST_DLL_WAIT = 2'd0;
   localparam logic [1:0] ST_START    = 2'd1;
   localparam logic [1:0] ST_RUN      = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   typedef enum logic [1:0] {
      DLL_WAIT = ST_DLL_WAIT,
      START    = ST_START,
      RUN      = ST_RUN,
      DONE     = ST_DONE
   } cal_state_t;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/qdrc_cal_wait_timer.sv
// Saturating up-counter: holds at LIMIT, synchronous clear wins over count enable.
// Exposes one bit tap of the running count and an expired flag at LIMIT.
module qdrc_cal_wait_timer #(
   parameter int               WIDTH   = 8,
   parameter int               TAP_BIT = 0,
   parameter logic [WIDTH-1:0] LIMIT   = '1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tap,
   output logic expired
);

   logic [WIDTH-1:0] count;

   assign tap     = count[TAP_BIT];
   assign expired = (count == LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/qdrc_phy_cal_seq.sv
// Calibration sequencer: DLL hold-off wait, then ordered stage start/done chain with bounded retries.
// Optional per-stage timeout is built in when QDRC_CAL_TIMEOUT_EN is defined.
module qdrc_phy_cal_seq
   import qdrc_cal_pkg::*;
#(
   parameter int NUM_STAGES   = 2,
   parameter int DLL_ON_BIT   = 17,
   parameter int WAIT_BIT     = 18,
   parameter int MAX_RETRIES  = 2,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    recal_req,
   output logic [NUM_STAGES-1:0]   stage_start,
   input  logic [NUM_STAGES-1:0]   stage_done,
   input  logic [NUM_STAGES-1:0]   stage_fail,
   output logic                    qdr_dll_off_n,
   output logic                    phy_rdy,
   output logic                    cal_fail,
   output logic                    cal_busy,
   output logic [FAIL_STAGE_W-1:0] fail_stage,
   output logic [RETRY_W-1:0]      retry_count
);

   localparam int               IDX_W    = (NUM_STAGES > 1) ? clog2(NUM_STAGES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   cal_state_t       state;
   logic [IDX_W-1:0] idx;
   logic             dll_on;
   logic             dll_wait_over;
   logic             stage_hit;
   logic             stage_bad;

   qdrc_cal_wait_timer #(
      .WIDTH   (WAIT_BIT + 1),
      .TAP_BIT (DLL_ON_BIT),
      .LIMIT   ({1'b1, {WAIT_BIT{1'b0}}})
   ) u_dll_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (1'b0),
      .en      (state == DLL_WAIT),
      .tap     (dll_on),
      .expired (dll_wait_over)
   );

`ifdef QDRC_CAL_TIMEOUT_EN
   logic tmo_tap;
   logic tmo_expired;
   logic timeout;

   qdrc_cal_wait_timer #(
      .WIDTH   (TIMEOUT_BITS),
      .TAP_BIT (TIMEOUT_BITS - 1),
      .LIMIT   ({TIMEOUT_BITS{1'b1}})
   ) u_tmo_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == START),
      .en      (state == RUN),
      .tap     (tmo_tap),
      .expired (tmo_expired)
   );

   // An all-ones count always has its MSB set; both terms describe the same limit.
   assign timeout   = tmo_expired && tmo_tap;
   // A real done in the timeout cycle decides the outcome on its own.
   assign stage_hit = stage_done[idx] || timeout;
   assign stage_bad = stage_done[idx] ? stage_fail[idx] : timeout;
`else
   assign stage_hit = stage_done[idx];
   assign stage_bad = stage_fail[idx];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= DLL_WAIT;
         idx           <= '0;
         stage_start   <= '0;
         qdr_dll_off_n <= 1'b0;
         phy_rdy       <= 1'b0;
         cal_fail      <= 1'b0;
         cal_busy      <= 1'b0;
         fail_stage    <= '0;
         retry_count   <= '0;
      end else begin
         stage_start <= '0;
         if (dll_on) begin
            qdr_dll_off_n <= 1'b1;
         end
         unique case (state)
            DLL_WAIT: begin
               if (dll_wait_over) begin
                  state          <= START;
                  idx            <= '0;
                  stage_start[0] <= 1'b1;
                  cal_busy       <= 1'b1;
               end
            end
            START: begin
               state <= RUN;
            end
            RUN: begin
               if (stage_hit) begin
                  if (!stage_bad) begin
                     if (idx == LAST_IDX) begin
                        state    <= DONE;
                        cal_busy <= 1'b0;
                        phy_rdy  <= 1'b1;
                     end else begin
                        state                      <= START;
                        idx                        <= idx + IDX_W'(1);
                        stage_start[idx + IDX_W'(1)] <= 1'b1;
                     end
                  end else begin
                     fail_stage <= FAIL_STAGE_W'(idx);
                     // Later stages depend on earlier ones, so a retry reruns the whole chain.
                     if (retry_count < RETRY_W'(MAX_RETRIES)) begin
                        state          <= START;
                        retry_count    <= retry_count + RETRY_W'(1);
                        idx            <= '0;
                        stage_start[0] <= 1'b1;
                     end else begin
                        state    <= DONE;
                        cal_fail <= 1'b1;
                        cal_busy <= 1'b0;
                        phy_rdy  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (recal_req) begin
                  state          <= START;
                  idx            <= '0;
                  stage_start[0] <= 1'b1;
                  cal_fail       <= 1'b0;
                  retry_count    <= '0;
                  fail_stage     <= '0;
                  phy_rdy        <= 1'b0;
                  cal_busy       <= 1'b1;
               end
            end
            default: begin
               state <= DLL_WAIT;
            end
         endcase
      end
   end

endmodule
